// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operands and controls in, result and status out.
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic             mul_en;
  logic [3:0]       ctrl_wrd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_out;
  logic             zero;
  logic             overflow;

  modport master (
    output start, mul_en, ctrl_wrd, a, b, carry_in,
    input  busy, done, result, result_hi, carry_out, zero, overflow
  );

  modport slave (
    input  start, mul_en, ctrl_wrd, a, b, carry_in,
    output busy, done, result, result_hi, carry_out, zero, overflow
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/add ops and a WIDTH-cycle unsigned shift-add multiply.
//   state | meaning
//   IDLE  | waiting for start; ALU ops complete from here in one cycle
//   MUL   | one shift-add step per cycle, down-counter tracks remaining steps
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  seq_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             carry_out_q, carry_out_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0]   a_p, b_p, alu_res;
  logic [WIDTH:0]     add_w, step_w;
  logic [2*WIDTH-1:0] prod;
  logic               alu_co, alu_ovf;

  always_comb begin
    a_p    = bus.ctrl_wrd[3] ? ~bus.a : bus.a;
    b_p    = bus.ctrl_wrd[2] ? ~bus.b : bus.b;
    add_w  = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, bus.carry_in};
    alu_co = 1'b0;
    alu_ovf = 1'b0;
    case (bus.ctrl_wrd[1:0])
      2'b00:   alu_res = a_p & b_p;
      2'b01:   alu_res = a_p | b_p;
      2'b10: begin
        alu_res = add_w[WIDTH-1:0];
        alu_co  = add_w[WIDTH];
        // Same-sign operands producing a different-sign sum is the MSB carry-in/out mismatch.
        alu_ovf = (a_p[WIDTH-1] == b_p[WIDTH-1]) && (add_w[WIDTH-1] != a_p[WIDTH-1]);
      end
      default: alu_res = bus.b;
    endcase

    // Product forms in {acc, mplier}: the partial sum shifts down into the vacated multiplier bits.
    step_w = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod   = {step_w, mplier_q[WIDTH-1:1]};

    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_out_d = carry_out_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.mul_en) begin
            mcand_d  = bus.a;
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH - 1);
            busy_d   = 1'b1;
            state_d  = MUL;
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            carry_out_d = alu_co;
            overflow_d  = alu_ovf;
            zero_d      = (alu_res == '0);
            done_d      = 1'b1;
          end
        end
      end
      MUL: begin
        {acc_d, mplier_d} = prod;
        if (cnt_q == '0) begin
          result_d    = prod[WIDTH-1:0];
          result_hi_d = prod[2*WIDTH-1:WIDTH];
          carry_out_d = 1'b0;
          overflow_d  = |prod[2*WIDTH-1:WIDTH];
          zero_d      = (prod == '0);
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_out_q <= carry_out_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.carry_out = carry_out_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8 with hand-computed expected values.
module tb_seq_alu;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  seq_alu_if #(.WIDTH(8)) bus ();

  seq_alu #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic me, input logic [3:0] ctrl,
                       input logic [7:0] av, input logic [7:0] bv, input logic cin);
    bus.start    = st;
    bus.mul_en   = me;
    bus.ctrl_wrd = ctrl;
    bus.a        = av;
    bus.b        = bv;
    bus.carry_in = cin;
  endtask

  // Issue a single-cycle ALU op; returns at the negedge in the completion cycle.
  task automatic alu_op(input logic [3:0] ctrl, input logic [7:0] av, input logic [7:0] bv,
                        input logic cin);
    @(negedge clk);
    drive(1'b1, 1'b0, ctrl, av, bv, cin);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 8'h5A, 8'hC3, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_res"}, 64'(bus.result), 64'h00);
    chk({tag, "_hi"}, 64'(bus.result_hi), 64'h00);
    chk({tag, "_co"}, 64'(bus.carry_out), 64'd0);
    chk({tag, "_ovf"}, 64'(bus.overflow), 64'd0);
    chk({tag, "_zero"}, 64'(bus.zero), 64'd1);
  endtask

  initial begin
    int lat;
    int done_seen;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    // First start accepted on the first edge after reset release
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 4'b0010, 8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
    chk("add_done", 64'(bus.done), 64'd1);
    chk("add_res", 64'(bus.result), 64'h80);
    chk("add_co", 64'(bus.carry_out), 64'd0);
    chk("add_ovf", 64'(bus.overflow), 64'd1);
    chk("add_zero", 64'(bus.zero), 64'd0);
    chk("add_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("add_done_drop", 64'(bus.done), 64'd0);
    chk("add_res_hold", 64'(bus.result), 64'h80);

    alu_op(4'b0110, 8'h05, 8'h05, 1'b1);
    chk("sub_res", 64'(bus.result), 64'h00);
    chk("sub_co", 64'(bus.carry_out), 64'd1);
    chk("sub_ovf", 64'(bus.overflow), 64'd0);
    chk("sub_zero", 64'(bus.zero), 64'd1);

    alu_op(4'b1100, 8'hF0, 8'h0F, 1'b0);
    chk("nor_res", 64'(bus.result), 64'h00);
    chk("nor_zero", 64'(bus.zero), 64'd1);
    chk("nor_co", 64'(bus.carry_out), 64'd0);

    alu_op(4'b0011, 8'hFF, 8'hA5, 1'b1);
    chk("pass_res", 64'(bus.result), 64'hA5);
    chk("pass_hi", 64'(bus.result_hi), 64'h00);
    chk("pass_co", 64'(bus.carry_out), 64'd0);

    alu_op(4'b0111, 8'h00, 8'h3C, 1'b0);
    chk("pass_noinv", 64'(bus.result), 64'h3C);

    alu_op(4'b0001, 8'h12, 8'h40, 1'b0);
    chk("or_res", 64'(bus.result), 64'h52);

    alu_op(4'b0000, 8'hF3, 8'h3F, 1'b0);
    chk("and_res", 64'(bus.result), 64'h33);

    alu_op(4'b0010, 8'hFF, 8'h01, 1'b0);
    chk("addc_res", 64'(bus.result), 64'h00);
    chk("addc_co", 64'(bus.carry_out), 64'd1);
    chk("addc_ovf", 64'(bus.overflow), 64'd0);
    chk("addc_zero", 64'(bus.zero), 64'd1);

    alu_op(4'b0010, 8'h80, 8'h80, 1'b0);
    chk("addn_ovf", 64'(bus.overflow), 64'd1);
    chk("addn_co", 64'(bus.carry_out), 64'd1);

    alu_op(4'b0010, 8'h10, 8'h22, 1'b1);
    chk("add_pre_mul", 64'(bus.result), 64'h33);

    // MUL FF*FF with an ignored start mid-multiply and one on the completion edge
    @(negedge clk);
    drive(1'b1, 1'b1, 4'b0110, 8'hFF, 8'hFF, 1'b1);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 0 || k == 3 || k == 8) drive(1'b0, 1'b0, 4'h0, 8'h11, 8'h22, 1'b0);
      if (k == 2) drive(1'b1, 1'b1, 4'h0, 8'h03, 8'h04, 1'b0);
      if (k == 7) drive(1'b1, 1'b1, 4'h0, 8'h02, 8'h02, 1'b0);
      chk($sformatf("mul_busy_c%0d", k), 64'(bus.busy), (k < 8) ? 64'd1 : 64'd0);
      chk($sformatf("mul_done_c%0d", k), 64'(bus.done), (k == 8) ? 64'd1 : 64'd0);
      if (k < 8) chk($sformatf("mul_hold_c%0d", k), 64'(bus.result), 64'h33);
      if (k == 8) begin
        chk("mulff_res", 64'(bus.result), 64'h01);
        chk("mulff_hi", 64'(bus.result_hi), 64'hFE);
        chk("mulff_ovf", 64'(bus.overflow), 64'd1);
        chk("mulff_co", 64'(bus.carry_out), 64'd0);
        chk("mulff_zero", 64'(bus.zero), 64'd0);
      end
    end

    alu_op(4'b0010, 8'h01, 8'h01, 1'b0);
    chk("add_post_mul_res", 64'(bus.result), 64'h02);
    chk("add_post_mul_hi", 64'(bus.result_hi), 64'h00);
    chk("add_post_mul_ovf", 64'(bus.overflow), 64'd0);

    @(negedge clk);
    drive(1'b1, 1'b1, 4'h0, 8'h03, 8'h04, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
      lat++;
    end while (!bus.done && lat < 20);
    chk("mul34_lat", 64'(lat), 64'd9);
    chk("mul34_res", 64'(bus.result), 64'h0C);
    chk("mul34_hi", 64'(bus.result_hi), 64'h00);
    chk("mul34_ovf", 64'(bus.overflow), 64'd0);

    // Reset asserted mid-cycle during a multiply
    @(negedge clk);
    drive(1'b1, 1'b1, 4'h0, 8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);

    alu_op(4'b0010, 8'h01, 8'h02, 1'b0);
    chk("post_rst_done", 64'(bus.done), 64'd1);
    chk("post_rst_res", 64'(bus.result), 64'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled on clk rising edge.
REQ-005 mul_en  input  1  1 = unsigned multi-cycle multiply; 0 = single-cycle ALU op.
REQ-006 ctrl_wrd  input  4  [3] invert a, [2] invert b, [1:0] select: 00 AND, 01 OR, 10 ADD, 11 pass b.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 carry_in  input  1  adder carry into bit 0.
REQ-010 busy  output  1  multiply in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result  output  WIDTH  ALU result, or low half of the product.
REQ-013 result_hi  output  WIDTH  high half of the product; 0 after ALU ops.
REQ-014 carry_out  output  1  adder carry out of the MSB.
REQ-015 zero  output  1  completed result equals 0.
REQ-016 overflow  output  1  signed ADD overflow, or multiply result_hi nonzero.

Function
REQ-017 The block SHALL implement the states IDLE and MUL.
REQ-018 All outputs SHALL be registered and SHALL hold their values until the next completion or reset.
REQ-019 In IDLE, start=1 with mul_en=0 SHALL compute the op at that edge and assert done for exactly the next cycle, giving latency 1; busy stays 0.
REQ-020 ALU op: A' = ctrl_wrd[3] ? ~a : a, B' = ctrl_wrd[2] ? ~b : b.
REQ-021 ALU op: AND = A'&B', OR = A'|B', ADD = A'+B'+carry_in, pass = raw b with no inversion.
REQ-022 Subtraction is ctrl_wrd=0110 with carry_in=1; NOR is ctrl_wrd=1100.
REQ-023 For ADD, carry_out SHALL be the carry out of bit WIDTH-1, and overflow SHALL be the carry into the MSB XOR the carry out of the MSB.
REQ-024 For non-ADD ops, carry_out=0 and overflow=0; after every ALU op, result_hi=0.
REQ-025 zero SHALL be 1 iff {result_hi,result}==0 at completion.
REQ-026 In IDLE, start=1 with mul_en=1 SHALL latch a and b, clear the accumulator, set busy=1 and enter MUL; ctrl_wrd and carry_in are ignored.
REQ-027 MUL SHALL perform one shift-add step per cycle, LSB-first on the multiplier, for exactly WIDTH steps.
REQ-028 On the WIDTH-th step edge the block SHALL update {result_hi,result} with the 2*WIDTH-bit unsigned product, set done=1 and busy=0, set carry_out=0, and return to IDLE.
REQ-029 Multiply timing: done is high in cycle WIDTH after the start edge; busy is high for exactly WIDTH cycles.
REQ-030 While busy, result, result_hi and the flags SHALL hold their previous values.
REQ-031 start while busy=1 SHALL be ignored and SHALL NOT queue.
REQ-032 start on the same edge that multiply completes SHALL be ignored; a new request is accepted from the following cycle.
REQ-033 done SHALL never be high for more than one consecutive cycle per accepted request.
REQ-034 Operand inputs may change after the start edge without affecting an accepted operation.

Reset
REQ-035 rst_n=0 SHALL immediately, without a clock edge, force: state IDLE, busy=0, done=0, result=0, result_hi=0, carry_out=0, overflow=0, zero=1, internal counter and accumulator=0.
REQ-036 Reset during MUL SHALL abort the multiply with no done pulse.
REQ-037 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-038 Reset asserted mid-cycle -> outputs take reset values (REQ-035) before the next edge.
REQ-039 ADD: ctrl 0010, a=7F, b=01, cin=0 -> next cycle done=1, result=80, carry_out=0, overflow=1, zero=0.
REQ-040 SUB: ctrl 0110, a=05, b=05, cin=1 -> result=00, carry_out=1, overflow=0, zero=1; then NOR ctrl 1100, a=F0, b=0F -> result=00, zero=1.
REQ-041 Pass b: ctrl 0011, a=FF, b=A5 -> result=A5, result_hi=00, carry_out=0.
REQ-042 MUL: a=FF, b=FF -> busy for 8 cycles, done in cycle 8, result_hi=FE, result=01, overflow=1; a start at cycle 3 with different operands is ignored; MUL 03*04 -> result=0C, result_hi=00, overflow=0.
REQ-043 MUL started, rst_n pulsed low at cycle 4 -> busy=0, no done, outputs at reset values; a subsequent ADD completes normally.
